// File: rtl/dbg_run_ctrl_if.sv
// Request/status bundle between a debug host and dbg_run_ctrl.
// The host drives the request strobes and channel mask; the controller drives the per-channel status.
interface dbg_run_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int STEP_W = 8
);
    logic              halt_req;
    logic              step_req;
    logic              resume_req;
    logic [NUM_CH-1:0] ch_sel;
    logic [STEP_W-1:0] step_count;
    logic [NUM_CH-1:0] bp_hit;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] halted;
    logic              busy;
    logic [NUM_CH-1:0] step_done;

    modport master (
        output halt_req, step_req, resume_req, ch_sel, step_count, bp_hit,
        input  clk_en, halted, busy, step_done
    );

    modport slave (
        input  halt_req, step_req, resume_req, ch_sel, step_count, bp_hit,
        output clk_en, halted, busy, step_done
    );
endinterface

// File: rtl/dbg_run_ctrl.sv
// Per-channel run/halt/step control of gated debug clocks.
// Define DBG_BREAKPOINT_EN to let bp_hit halt a running channel or abort a step.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_RUN  | free running, clk_en high
//   ST_HALT | clock stopped, clk_en low, waiting for step/resume
//   ST_STEP | clk_en high while the step down-counter runs to 1
module dbg_run_ctrl #(
    parameter int NUM_CH = 2,
    parameter int STEP_W = 8
) (
    input  logic           sys_clk,
    input  logic           dbg_rst,
    dbg_run_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STEP} state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [STEP_W-1:0] cnt_q   [NUM_CH];
    logic [STEP_W-1:0] cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] clk_en_q;
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] done_d;
    logic [NUM_CH-1:0] bp_live;
    logic [NUM_CH-1:0] in_step;
    logic              do_halt;
    logic              do_step;
    logic              do_resume;

    // One strobe wins per cycle, even if it turns out to be ignored by the channel.
    assign do_halt   = bus.halt_req;
    assign do_step   = bus.step_req & ~bus.halt_req;
    assign do_resume = bus.resume_req & ~bus.step_req & ~bus.halt_req;

`ifdef DBG_BREAKPOINT_EN
    assign bp_live = bus.bp_hit;
`else
    assign bp_live = bus.bp_hit & {NUM_CH{1'b0}};
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            done_d[c]  = 1'b0;
            case (state_q[c])
                ST_RUN: begin
                    if ((do_halt && bus.ch_sel[c]) || bp_live[c])
                        state_d[c] = ST_HALT;
                end
                ST_HALT: begin
                    if (bus.ch_sel[c] && do_step) begin
                        if (bus.step_count == '0) begin
                            done_d[c] = 1'b1;
                        end else begin
                            state_d[c] = ST_STEP;
                            cnt_d[c]   = bus.step_count;
                        end
                    end else if (bus.ch_sel[c] && do_resume) begin
                        state_d[c] = ST_RUN;
                    end
                end
                ST_STEP: begin
                    if ((do_halt && bus.ch_sel[c]) || bp_live[c]) begin
                        state_d[c] = ST_HALT;
                        cnt_d[c]   = '0;
                    end else if (cnt_q[c] == STEP_W'(1)) begin
                        state_d[c] = ST_HALT;
                        cnt_d[c]   = '0;
                        done_d[c]  = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] - STEP_W'(1);
                    end
                end
                default: begin
                    state_d[c] = ST_RUN;
                    cnt_d[c]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!dbg_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_RUN;
                cnt_q[c]   <= '0;
            end
            clk_en_q <= '1;
            done_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                cnt_q[c]    <= cnt_d[c];
                clk_en_q[c] <= (state_d[c] != ST_HALT);
            end
            done_q <= done_d;
        end
    end

    always_comb begin
        bus.halted = '0;
        in_step    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.halted[c] = (state_q[c] == ST_HALT);
            in_step[c]    = (state_q[c] == ST_STEP);
        end
    end

    assign bus.busy      = |in_step;
    assign bus.clk_en    = clk_en_q;
    assign bus.step_done = done_q;
endmodule
